// File: rtl/ctl_score_bcd_pkg.sv
// ctl_score_pkg: shared BCD digit type, digit ceiling and hit-point clamp helper
package ctl_score_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  typedef logic [3:0] bcd_digit_t;
  function automatic bcd_digit_t bcd_clamp(input logic [31:0] pts);
    return pts > 32'(BCD_MAX) ? BCD_MAX : pts[3:0];
  endfunction
endpackage

// File: rtl/ctl_score_bcd_if.sv
// ctl_score_bcd_if: hit/reset_score/hit_points from master; score, high_score, new_high, overflow from slave
interface ctl_score_bcd_if #(parameter int DIGITS = 2, parameter int PTS_W = 4);
  logic reset_score;
  logic hit;
  logic [PTS_W-1:0] hit_points;
  logic [4*DIGITS-1:0] score;
  logic [4*DIGITS-1:0] high_score;
  logic new_high;
  logic overflow;
  modport master (output reset_score, hit, hit_points, input score, high_score, new_high, overflow);
  modport slave (input reset_score, hit, hit_points, output score, high_score, new_high, overflow);
endinterface

// File: rtl/ctl_score_bcd_digit_add.sv
// ctl_bcd_digit_add: one BCD digit adder; a, b, cin in, sum digit and cout out
import ctl_score_pkg::*;
module ctl_bcd_digit_add (
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);
  logic [4:0] s;
  always_comb begin
    s = 5'(a) + 5'(b) + 5'(cin);
    cout = s > 5'd9;
    sum = cout ? 4'(s - 5'd10) : s[3:0];
  end
endmodule

// File: rtl/ctl_score_bcd.sv
// ctl_score_bcd: packed-BCD score with saturate/wrap, session high score and sticky flags; ports clk, rst, bus (slave)
import ctl_score_pkg::*;
module ctl_score_bcd #(
  parameter int DIGITS = 2,
  parameter int PTS_W = 4,
  parameter bit SATURATE = 1'b1
) (
  input logic clk,
  input logic rst,
  ctl_score_bcd_if.slave bus
);
  logic [4*DIGITS-1:0] score_q, high_q, sum, score_nxt;
  logic [DIGITS:0] c;
  logic new_high_q, ovf_q;
  bcd_digit_t p;
  assign p = bcd_clamp(32'(bus.hit_points));
  assign c[0] = 1'b0;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    ctl_bcd_digit_add u_add (
      .a(score_q[4*i+:4]),
      .b(i == 0 ? p : 4'd0),
      .cin(c[i]),
      .sum(sum[4*i+:4]),
      .cout(c[i+1])
    );
  end
  assign score_nxt = (SATURATE && c[DIGITS]) ? {DIGITS{BCD_MAX}} : sum;
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= '0;
      high_q <= '0;
      new_high_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (bus.reset_score) begin
        score_q <= '0;
        ovf_q <= 1'b0;
        new_high_q <= 1'b0;
      end else begin
        if (bus.hit) begin
          score_q <= score_nxt;
          if (c[DIGITS]) ovf_q <= 1'b1;
        end
        if (score_q > high_q) new_high_q <= 1'b1;
      end
      if (score_q > high_q) high_q <= score_q;
    end
  end
  assign bus.score = score_q;
  assign bus.high_score = high_q;
  assign bus.new_high = new_high_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ctl_score_bcd.sv
// tb_ctl_score_bcd: scoreboard bench driving a saturating and a wrapping 2-digit score counter
module tb_ctl_score_bcd;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ctl_score_bcd_if #(.DIGITS(2), .PTS_W(4)) if_s ();
  ctl_score_bcd_if #(.DIGITS(2), .PTS_W(4)) if_w ();
  ctl_score_bcd #(.DIGITS(2), .PTS_W(4), .SATURATE(1'b1)) u_sat (.clk(clk), .rst(rst), .bus(if_s.slave));
  ctl_score_bcd #(.DIGITS(2), .PTS_W(4), .SATURATE(1'b0)) u_wrap (.clk(clk), .rst(rst), .bus(if_w.slave));
  typedef struct packed {
    logic [7:0] s1, h1;
    logic n1, o1;
    logic [7:0] s0, h0;
    logic n0, o0;
    int row;
  } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int row = 0;
  task automatic chk(input string name, input int r, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL row%0d %s got=%h want=%h", r, name, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sat.score", e.row, if_s.score, e.s1);
      chk("sat.high", e.row, if_s.high_score, e.h1);
      chk("sat.new_high", e.row, 8'(if_s.new_high), 8'(e.n1));
      chk("sat.overflow", e.row, 8'(if_s.overflow), 8'(e.o1));
      chk("wrap.score", e.row, if_w.score, e.s0);
      chk("wrap.high", e.row, if_w.high_score, e.h0);
      chk("wrap.new_high", e.row, 8'(if_w.new_high), 8'(e.n0));
      chk("wrap.overflow", e.row, 8'(if_w.overflow), 8'(e.o0));
    end
  end
  task automatic step2(input logic r, input logic rs, input logic h, input logic [3:0] pts,
                       input logic [7:0] s1, input logic [7:0] h1, input logic n1, input logic o1,
                       input logic [7:0] s0, input logic [7:0] h0, input logic n0, input logic o0);
    exp_t e;
    rst = r;
    if_s.reset_score = rs;
    if_w.reset_score = rs;
    if_s.hit = h;
    if_w.hit = h;
    if_s.hit_points = pts;
    if_w.hit_points = pts;
    @(posedge clk);
    e = '{s1: s1, h1: h1, n1: n1, o1: o1, s0: s0, h0: h0, n0: n0, o0: o0, row: row};
    q.push_back(e);
    row++;
    #1;
  endtask
  task automatic step(input logic r, input logic rs, input logic h, input logic [3:0] pts,
                      input logic [7:0] s, input logic [7:0] hs, input logic n, input logic o);
    step2(r, rs, h, pts, s, hs, n, o, s, hs, n, o);
  endtask
  initial begin
    if_s.reset_score = 1'b0; if_w.reset_score = 1'b0;
    if_s.hit = 1'b0; if_w.hit = 1'b0;
    if_s.hit_points = '0; if_w.hit_points = '0;
    step(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    step(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    step(0, 0, 1, 1, 8'h01, 8'h00, 0, 0);
    step(0, 0, 1, 1, 8'h02, 8'h01, 1, 0);
    step(0, 0, 1, 1, 8'h03, 8'h02, 1, 0);
    step(0, 0, 0, 0, 8'h03, 8'h03, 1, 0);
    step(0, 0, 1, 15, 8'h12, 8'h03, 1, 0);
    step(0, 0, 1, 6, 8'h18, 8'h12, 1, 0);
    step(0, 0, 1, 5, 8'h23, 8'h18, 1, 0);
    step(0, 0, 1, 12, 8'h32, 8'h23, 1, 0);
    step(0, 0, 0, 0, 8'h32, 8'h32, 1, 0);
    step(0, 0, 1, 9, 8'h41, 8'h32, 1, 0);
    step(0, 0, 1, 9, 8'h50, 8'h41, 1, 0);
    step(0, 0, 1, 9, 8'h59, 8'h50, 1, 0);
    step(0, 0, 1, 9, 8'h68, 8'h59, 1, 0);
    step(0, 0, 1, 9, 8'h77, 8'h68, 1, 0);
    step(0, 0, 1, 9, 8'h86, 8'h77, 1, 0);
    step(0, 0, 1, 9, 8'h95, 8'h86, 1, 0);
    step2(0, 0, 1, 7, 8'h99, 8'h95, 1, 1, 8'h02, 8'h95, 1, 1);
    step2(0, 0, 1, 1, 8'h99, 8'h99, 1, 1, 8'h03, 8'h95, 1, 1);
    step2(0, 0, 0, 0, 8'h99, 8'h99, 1, 1, 8'h03, 8'h95, 1, 1);
    step(1, 0, 1, 5, 8'h00, 8'h00, 0, 0);
    step(0, 0, 1, 9, 8'h09, 8'h00, 0, 0);
    step(0, 0, 1, 9, 8'h18, 8'h09, 1, 0);
    step(0, 0, 1, 9, 8'h27, 8'h18, 1, 0);
    step(0, 0, 1, 9, 8'h36, 8'h27, 1, 0);
    step(0, 0, 1, 4, 8'h40, 8'h36, 1, 0);
    step(0, 0, 0, 0, 8'h40, 8'h40, 1, 0);
    step(0, 1, 1, 5, 8'h00, 8'h40, 0, 0);
    step(0, 0, 1, 3, 8'h03, 8'h40, 0, 0);
    step(0, 0, 0, 0, 8'h03, 8'h40, 0, 0);
    step(0, 0, 1, 9, 8'h12, 8'h40, 0, 0);
    step(0, 0, 1, 9, 8'h21, 8'h40, 0, 0);
    step(0, 0, 1, 9, 8'h30, 8'h40, 0, 0);
    step(0, 0, 1, 9, 8'h39, 8'h40, 0, 0);
    step(0, 0, 1, 9, 8'h48, 8'h40, 0, 0);
    step(0, 0, 1, 9, 8'h57, 8'h48, 1, 0);
    step(0, 0, 0, 0, 8'h57, 8'h57, 1, 0);
    step(1, 0, 1, 3, 8'h00, 8'h00, 0, 0);
    step(0, 0, 1, 0, 8'h00, 8'h00, 0, 0);
    step(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ctl_score_bcd.md
Name: ctl_score_bcd

Overview:
Parametrised successor of the two-digit hit counter. It keeps a DIGITS-wide packed-BCD game score that advances by a per-hit point value (0..9), with a selectable saturate or wrap policy at the top of the range. It also keeps a session high score, a per-round "new high" flag and a sticky overflow flag. It sits between the hit-detection logic and the 7-segment driver; each BCD nibble of score drives one display digit.

Parameters:
DIGITS, 2, number of BCD digits in score/high_score (1..8)
PTS_W, 4, width of hit_points input
SATURATE, 1, 1: clamp at all-9s on overflow; 0: wrap modulo 10^DIGITS

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset, clears all state
reset_score  in  1  start of new round: clears score, overflow, new_high
hit  in  1  single-cycle qualifier: add hit_points this cycle
hit_points  in  PTS_W  points for this hit, binary; values >9 clamped to 9
score  out  4*DIGITS  current score, packed BCD, digit 0 in [3:0]
high_score  out  4*DIGITS  session maximum of score, packed BCD
new_high  out  1  sticky: high_score raised during current round
overflow  out  1  sticky: an add exceeded 10^DIGITS-1 during current round

Behaviour:
- Everything is registered on posedge clk. Synchronous active-high reset. One clock, no CDC.
- rst=1: score, high_score = 0; new_high, overflow = 0. rst has priority over all other inputs.
- Priority order: rst > reset_score > hit.
- reset_score=1:
  - score=0, overflow=0, new_high=0 next cycle.
  - A coincident hit is dropped.
  - high_score is kept.
- hit=1 with points p = min(hit_points, 9):
  - score_nxt = score + p, computed as a digit-serial BCD ripple: digit 0 takes p as addend and carry-in 0; digits 1..DIGITS-1 take addend 0 plus the carry from the digit below.
  - Each digit's sum s = a + b + cin (0..19). If s > 9: digit = s - 10 and carry out = 1.
  - Latency is 1 cycle: score reflects the hit on the clock edge after hit is sampled.
- p=0 with hit=1: score unchanged, no flag changes.
- Carry out of the top digit (overflow condition):
  - SATURATE=1: score = all digits 9 and overflow <= 1.
  - SATURATE=0: score = wrapped ripple result (modulo 10^DIGITS) and overflow <= 1.
  - overflow stays 1 until rst or reset_score.
- When score is already all 9s with SATURATE=1, every further nonzero hit re-asserts overflow; score holds.
- hit=0: score holds; the held value remains valid BCD.
- high_score update:
  - Every cycle, if registered score > high_score, then high_score <= score and new_high <= 1.
  - Packed-BCD unsigned compare equals decimal compare.
  - high_score lags score by 1 cycle, so it reflects a hit 2 cycles after hit is sampled.
- new_high is cleared only by rst or reset_score. A raise in the same cycle as reset_score is lost (reset_score wins).
- Wrap with SATURATE=0 never lowers high_score.
- Outputs are never X after the first rst cycle. Invalid BCD cannot arise internally.

Decomposition:
- Package ctl_score_pkg:
  - BCD_MAX = 4'd9
  - typedef bcd_digit_t (logic [3:0])
  - function bcd_clamp(pts) returning bcd_digit_t
- Sub-module ctl_bcd_digit_add: a, b, cin -> sum digit, cout. Purely combinational, instantiated DIGITS times in a generate loop.
- Top level holds the registers, priority logic, saturate mux and compare.

Test Plan:
1. Use DIGITS=2, SATURATE=1. Assert rst 2 cycles, then 3 hits with hit_points=1 -> score 0x01, 0x02, 0x03, each 1 cycle after its hit. high_score=0x03 one cycle later; new_high=1.
2. From score=0x18, hit with hit_points=5 -> score 0x23 (digit carry). Then hit with hit_points=12 -> clamped to 9, score 0x32.
3. SATURATE=1, score=0x95, hit with hit_points=7 -> score 0x99, overflow=1. Another hit with hit_points=1 -> score 0x99, overflow stays 1.
4. SATURATE=0, score=0x95, hit with hit_points=7 -> score 0x02, overflow=1, high_score stays 0x95.
5. Drive reset_score and hit(5) in the same cycle with score=0x40, high_score=0x40 -> score 0x00, overflow=0, new_high=0, high_score 0x40. Next hit with hit_points=3 -> score 0x03, high_score unchanged, new_high stays 0.
6. Assert rst mid-round with score=0x57, high_score=0x57 -> all outputs 0 next cycle. hit_points=0 with hit=1 -> no change.
